csr_file_ext: RTL and testbench
===============================

Name: csr_file_ext

Overview:
Parametrised machine-mode CSR file for the core. It serves ex (read, plus RW/RS/RC read-modify-write) and clint (read, plus plain write). It holds the machine trap CSRs, mscratch, mhartid, mcountinhibit and CNT_W-bit mcycle/minstret counters with user read-only aliases. It flags illegal CSR accesses back to ex and exports trap state to clint.

Parameters:
XLEN, 32, register/data width
CNT_W, 64, counter width; XLEN < CNT_W <= 2*XLEN
HART_ID, 0, value returned by mhartid
MTVEC_RST, 0, reset value of mtvec

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ex_op_i  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
ex_addr_i  in  12  ex CSR address (read and write)
ex_data_i  in  XLEN  ex operand
ex_data_o  out  XLEN  old value of ex_addr_i
ex_illegal_o  out  1  illegal access
retire_i  in  1  one instruction retired this cycle
clint_we_i  in  1  clint write enable
clint_waddr_i  in  12  clint write address
clint_raddr_i  in  12  clint read address
clint_data_i  in  XLEN  clint write data
clint_data_o  out  XLEN  clint read data
mtvec_o, mepc_o, mstatus_o, mie_o  out  XLEN each  register values
global_int_en_o  out  1  mstatus[3]

Behaviour:
- Reset: rst low asynchronously clears all registers. mtvec <= MTVEC_RST. All outputs are 0 except mtvec_o = MTVEC_RST and ex/clint read data for mtvec/mhartid.
- Address map:
  - mstatus 0x300: only bits 3 (MIE) and 7 (MPIE) are stored; other bits read 0.
  - mie 0x304.
  - mtvec 0x305: bits[1:0] read 0.
  - mcountinhibit 0x320: bits 0 (CY) and 2 (IR) only.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82: read-only aliases.
  - mhartid 0xF14: read-only, HART_ID.
- High halves return counter[CNT_W-1:XLEN], zero-extended.
- Reads are combinational and return the pre-write register state (no write bypass). Unmapped address reads 0 on both ports.
- ex_op_i != 00:
  - new = RW: data; RS: old | data; RC: old & ~data.
  - Written at the next posedge.
  - RS/RC with ex_data_i == 0 performs no write (read only).
- ex_illegal_o = op != 00 && (address unmapped || (address[11:10] == 2'b11 && a write would occur)).
  - Combinational; an illegal access performs no state change.
  - clint reads/writes never raise illegal; clint writes to read-only or unmapped addresses are ignored.
- Simultaneous writes:
  - Different registers: both take effect.
  - Same register: ex wins, clint value dropped.
- Counters:
  - mcycle increments every cycle when CY=0.
  - minstret increments when retire_i=1 and IR=0.
  - Both wrap from 2^CNT_W-1 to 0.
  - A write to the low or high half in a cycle replaces the increment for that cycle; the other half is kept.
  - A write of CY/IR=1 takes effect from the next cycle.
- The mstatus, mie, mtvec and mepc outputs are direct register views; global_int_en_o = mstatus[3].
- Reset asserted mid-access: the access is lost and the state goes to reset values immediately.

Test Plan:
- Release reset, idle 10 clk -> cycle read = 10 (±1 per sampling edge), cycleh = 0, mtvec_o = MTVEC_RST, ex_illegal_o = 0.
- ex RW 0x300 data 0xFFFFFFFF, then RC data 0x8 -> mstatus reads 0x88 then 0x80; global_int_en_o goes 1 then 0; ex_data_o on the RC shows 0x88.
- mcycle write 0xFFFFFFFF with CNT_W=64 -> next cycle mcycle = 0 and mcycleh = 1. Set mcountinhibit=0x1 -> mcycle frozen; retire_i pulses still advance minstret.
- ex RW 0xC00, and ex RW 0x7C0 (unmapped) -> ex_illegal_o = 1, no state change. ex RS 0xC00 data 0 -> legal read.
- Same-cycle ex RW mepc=0x100 and clint mepc=0x200 -> mepc = 0x100. Ex mscratch + clint mcause in one cycle -> both written.
- Drop rst during an ex write to mtvec -> mtvec_o = MTVEC_RST immediately, no write after release.

Source files
------------

// File: rtl/csr_file_ext.sv
// Machine-mode CSR file: trap CSRs, mscratch, mhartid, mcountinhibit and the
// mcycle/minstret counters, shared by the ex read-modify-write port and the clint port.
module csr_file_ext #(
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 64,
  parameter int unsigned HART_ID   = 0,
  parameter int unsigned MTVEC_RST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ex_op_i,
  input  logic [11:0]      ex_addr_i,
  input  logic [XLEN-1:0]  ex_data_i,
  output logic [XLEN-1:0]  ex_data_o,
  output logic             ex_illegal_o,
  input  logic             retire_i,
  input  logic             clint_we_i,
  input  logic [11:0]      clint_waddr_i,
  input  logic [11:0]      clint_raddr_i,
  input  logic [XLEN-1:0]  clint_data_i,
  output logic [XLEN-1:0]  clint_data_o,
  output logic [XLEN-1:0]  mtvec_o,
  output logic [XLEN-1:0]  mepc_o,
  output logic [XLEN-1:0]  mstatus_o,
  output logic [XLEN-1:0]  mie_o,
  output logic             global_int_en_o
);

  localparam int HW = CNT_W - XLEN;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCINH    = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTR    = 12'hC02;
  localparam logic [11:0] A_INSTRH   = 12'hC82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_NONE     = 12'h000;

  localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(8'h88);
  localparam logic [XLEN-1:0] CINH_MASK    = XLEN'(8'h05);
  localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(2'b11);
  localparam logic [XLEN-1:0] MTVEC_RST_V  = XLEN'(MTVEC_RST) & ALIGN_MASK;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

  logic [XLEN-1:0]  mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0]  mcinh_q, mcinh_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0]  mepc_q, mepc_d, mcause_q, mcause_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [XLEN-1:0]  ex_old_s, ex_new_s;
  logic             ex_wants_s, ex_illegal_s, ex_we_s, clint_we_s;
  logic             wen_s [2];
  logic [11:0]      wad_s [2];
  logic [XLEN-1:0]  wdat_s [2];
  logic [11:0]      wsel_s;
  logic             cyc_hit_s, ins_hit_s;
  logic [CNT_W-1:0] cyc_base_s, ins_base_s;

  function automatic logic is_mapped(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MIE, A_MTVEC, A_MCINH, A_MSCRATCH, A_MEPC, A_MCAUSE,
      A_MCYCLE, A_MCYCLEH, A_MINSTR, A_MINSTRH,
      A_CYCLE, A_CYCLEH, A_INSTR, A_INSTRH, A_MHARTID: is_mapped = 1'b1;
      default:                                        is_mapped = 1'b0;
    endcase
  endfunction

  // High counter halves are zero-extended when CNT_W < 2*XLEN.
  function automatic logic [XLEN-1:0] rd_csr(input logic [11:0] a);
    case (a)
      A_MSTATUS:           rd_csr = mstatus_q;
      A_MIE:               rd_csr = mie_q;
      A_MTVEC:             rd_csr = mtvec_q;
      A_MCINH:             rd_csr = mcinh_q;
      A_MSCRATCH:          rd_csr = mscratch_q;
      A_MEPC:              rd_csr = mepc_q;
      A_MCAUSE:            rd_csr = mcause_q;
      A_MCYCLE, A_CYCLE:   rd_csr = mcycle_q[XLEN-1:0];
      A_MCYCLEH, A_CYCLEH: rd_csr = XLEN'(mcycle_q[CNT_W-1:XLEN]);
      A_MINSTR, A_INSTR:   rd_csr = minstret_q[XLEN-1:0];
      A_MINSTRH, A_INSTRH: rd_csr = XLEN'(minstret_q[CNT_W-1:XLEN]);
      A_MHARTID:           rd_csr = XLEN'(HART_ID);
      default:             rd_csr = '0;
    endcase
  endfunction

  // ex access decode: old value, modified value, legality and effective write enables.
  always_comb begin
    ex_old_s = rd_csr(ex_addr_i);
    case (ex_op_i)
      2'b01:   ex_new_s = ex_data_i;
      2'b10:   ex_new_s = ex_old_s | ex_data_i;
      2'b11:   ex_new_s = ex_old_s & ~ex_data_i;
      default: ex_new_s = ex_old_s;
    endcase
    ex_wants_s   = (ex_op_i == 2'b01) || ((ex_op_i != 2'b00) && (ex_data_i != '0));
    ex_illegal_s = (ex_op_i != 2'b00) &&
                   (!is_mapped(ex_addr_i) || ((ex_addr_i[11:10] == 2'b11) && ex_wants_s));
    ex_we_s      = ex_wants_s && !ex_illegal_s;
    clint_we_s   = clint_we_i && is_mapped(clint_waddr_i) && (clint_waddr_i[11:10] != 2'b11) &&
                   !(ex_we_s && (ex_addr_i == clint_waddr_i));
    wen_s[0]  = clint_we_s;
    wad_s[0]  = clint_waddr_i;
    wdat_s[0] = clint_data_i;
    wen_s[1]  = ex_we_s;
    wad_s[1]  = ex_addr_i;
    wdat_s[1] = ex_new_s;
  end

  // Next state: counters advance unless a half is written; ex is applied after clint.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mcinh_d    = mcinh_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcinh_q[0] ? mcycle_q : mcycle_q + CNT_ONE;
    minstret_d = (retire_i && !mcinh_q[2]) ? minstret_q + CNT_ONE : minstret_q;
    cyc_hit_s  = 1'b0;
    ins_hit_s  = 1'b0;
    cyc_base_s = mcycle_q;
    ins_base_s = minstret_q;
    wsel_s     = A_NONE;
    for (int p = 0; p < 2; p++) begin
      wsel_s     = wen_s[p] ? wad_s[p] : A_NONE;
      cyc_base_s = cyc_hit_s ? mcycle_d : mcycle_q;
      ins_base_s = ins_hit_s ? minstret_d : minstret_q;
      case (wsel_s)
        A_MSTATUS:  mstatus_d  = wdat_s[p] & MSTATUS_MASK;
        A_MIE:      mie_d      = wdat_s[p];
        A_MTVEC:    mtvec_d    = wdat_s[p] & ALIGN_MASK;
        A_MCINH:    mcinh_d    = wdat_s[p] & CINH_MASK;
        A_MSCRATCH: mscratch_d = wdat_s[p];
        A_MEPC:     mepc_d     = wdat_s[p] & ALIGN_MASK;
        A_MCAUSE:   mcause_d   = wdat_s[p];
        A_MCYCLE: begin
          mcycle_d  = {cyc_base_s[CNT_W-1:XLEN], wdat_s[p]};
          cyc_hit_s = 1'b1;
        end
        A_MCYCLEH: begin
          mcycle_d  = {wdat_s[p][HW-1:0], cyc_base_s[XLEN-1:0]};
          cyc_hit_s = 1'b1;
        end
        A_MINSTR: begin
          minstret_d = {ins_base_s[CNT_W-1:XLEN], wdat_s[p]};
          ins_hit_s  = 1'b1;
        end
        A_MINSTRH: begin
          minstret_d = {wdat_s[p][HW-1:0], ins_base_s[XLEN-1:0]};
          ins_hit_s  = 1'b1;
        end
        default: begin
          cyc_hit_s = cyc_hit_s;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST_V;
      mcinh_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mcinh_q    <= mcinh_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign ex_data_o       = ex_old_s;
  assign ex_illegal_o    = ex_illegal_s;
  assign clint_data_o    = rd_csr(clint_raddr_i);
  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign mstatus_o       = mstatus_q;
  assign mie_o           = mie_q;
  assign global_int_en_o = mstatus_q[3];

endmodule

// File: tb/tb_csr_file_ext.sv
// Bench for csr_file_ext: an address-map model checked every negedge, plus directed
// scenarios with hand-computed values.
module tb_csr_file_ext;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ex_op_i = 2'b00;
  logic [11:0] ex_addr_i = 12'h000;
  logic [31:0] ex_data_i = 32'h0;
  logic [31:0] ex_data_o;
  logic        ex_illegal_o;
  logic        retire_i = 1'b0;
  logic        clint_we_i = 1'b0;
  logic [11:0] clint_waddr_i = 12'h000;
  logic [11:0] clint_raddr_i = 12'hC00;
  logic [31:0] clint_data_i = 32'h0;
  logic [31:0] clint_data_o, mtvec_o, mepc_o, mstatus_o, mie_o;
  logic        global_int_en_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_file_ext #(.XLEN(32), .CNT_W(64), .HART_ID(3), .MTVEC_RST(32'h80)) dut (
    .clk(clk), .rst(rst),
    .ex_op_i(ex_op_i), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i),
    .ex_data_o(ex_data_o), .ex_illegal_o(ex_illegal_o), .retire_i(retire_i),
    .clint_we_i(clint_we_i), .clint_waddr_i(clint_waddr_i), .clint_raddr_i(clint_raddr_i),
    .clint_data_i(clint_data_i), .clint_data_o(clint_data_o),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mstatus_o(mstatus_o), .mie_o(mie_o),
    .global_int_en_o(global_int_en_o)
  );

  typedef struct packed {
    logic [31:0] mstatus, mie, mtvec, cinh, mscratch, mepc, mcause;
    logic [63:0] mcycle, minstret;
  } mst_t;

  localparam mst_t M_RST = '{mstatus: 32'h0, mie: 32'h0, mtvec: 32'h80, cinh: 32'h0,
                             mscratch: 32'h0, mepc: 32'h0, mcause: 32'h0,
                             mcycle: 64'h0, minstret: 64'h0};
  mst_t m = M_RST;

  function automatic logic is_map(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                     12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                     12'hC82, 12'hF14};
  endfunction

  function automatic logic [31:0] mread(input mst_t s, input logic [11:0] a);
    case (a)
      12'h300: return s.mstatus;
      12'h304: return s.mie;
      12'h305: return s.mtvec;
      12'h320: return s.cinh;
      12'h340: return s.mscratch;
      12'h341: return s.mepc;
      12'h342: return s.mcause;
      12'hB00, 12'hC00: return s.mcycle[31:0];
      12'hB80, 12'hC80: return s.mcycle[63:32];
      12'hB02, 12'hC02: return s.minstret[31:0];
      12'hB82, 12'hC82: return s.minstret[63:32];
      12'hF14: return 32'd3;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_writes(input logic [1:0] op, input logic [31:0] d);
    return (op == 2'b01) || (op != 2'b00 && d != 32'd0);
  endfunction

  function automatic logic m_illegal(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    return (op != 2'b00) && (!is_map(a) || (a[11:10] == 2'b11 && m_writes(op, d)));
  endfunction

  // One clock edge of the architectural model: clint write first, ex write overrides.
  function automatic mst_t mstep(input mst_t s, input logic [1:0] op, input logic [11:0] ea,
                                 input logic [31:0] ed, input logic ret, input logic cwe,
                                 input logic [11:0] ca, input logic [31:0] cd);
    mst_t n = s;
    logic exw, clw;
    logic [31:0] old, nv;
    logic [11:0] wa [2];
    logic [31:0] wd [2];
    logic we [2];
    logic [31:0] clo, chi, ilo, ihi;
    logic ct, it;
    old = mread(s, ea);
    nv  = (op == 2'b01) ? ed : (op == 2'b10) ? (old | ed) : (old & ~ed);
    exw = m_writes(op, ed) && !m_illegal(op, ea, ed);
    clw = cwe && is_map(ca) && ca[11:10] != 2'b11 && !(exw && ca == ea);
    we[0] = clw; wa[0] = ca; wd[0] = cd;
    we[1] = exw; wa[1] = ea; wd[1] = nv;
    clo = s.mcycle[31:0];   chi = s.mcycle[63:32];   ct = 1'b0;
    ilo = s.minstret[31:0]; ihi = s.minstret[63:32]; it = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (we[i]) begin
        case (wa[i])
          12'h300: n.mstatus  = wd[i] & 32'h88;
          12'h304: n.mie      = wd[i];
          12'h305: n.mtvec    = wd[i] & 32'hFFFF_FFFC;
          12'h320: n.cinh     = wd[i] & 32'h5;
          12'h340: n.mscratch = wd[i];
          12'h341: n.mepc     = wd[i] & 32'hFFFF_FFFC;
          12'h342: n.mcause   = wd[i];
          12'hB00: begin clo = wd[i]; ct = 1'b1; end
          12'hB80: begin chi = wd[i]; ct = 1'b1; end
          12'hB02: begin ilo = wd[i]; it = 1'b1; end
          12'hB82: begin ihi = wd[i]; it = 1'b1; end
          default: ;
        endcase
      end
    end
    n.mcycle   = ct ? {chi, clo} : (s.cinh[0] ? s.mcycle : s.mcycle + 64'd1);
    n.minstret = it ? {ihi, ilo} : ((ret && !s.cinh[2]) ? s.minstret + 64'd1 : s.minstret);
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= M_RST;
    else      m <= mstep(m, ex_op_i, ex_addr_i, ex_data_i, retire_i,
                         clint_we_i, clint_waddr_i, clint_data_i);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge.
  always @(negedge clk) begin
    chk("m_ex_data", ex_data_o, mread(m, ex_addr_i));
    chk("m_ex_illegal", {31'd0, ex_illegal_o}, {31'd0, m_illegal(ex_op_i, ex_addr_i, ex_data_i)});
    chk("m_clint_data", clint_data_o, mread(m, clint_raddr_i));
    chk("m_mtvec", mtvec_o, m.mtvec);
    chk("m_mepc", mepc_o, m.mepc);
    chk("m_mstatus", mstatus_o, m.mstatus);
    chk("m_mie", mie_o, m.mie);
    chk("m_gie", {31'd0, global_int_en_o}, {31'd0, m.mstatus[3]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    ex_op_i = op; ex_addr_i = a; ex_data_i = d;
  endtask

  task automatic cw(input logic [11:0] a, input logic [31:0] d);
    clint_we_i = 1'b1; clint_waddr_i = a; clint_data_i = d;
  endtask

  task automatic quiet();
    ex_op_i = 2'b00; clint_we_i = 1'b0; retire_i = 1'b0;
  endtask

  task automatic rdc(input string nm, input logic [11:0] a, input logic [31:0] exp);
    clint_raddr_i = a;
    #1;
    chk(nm, clint_data_o, exp);
  endtask

  initial begin
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mtvec", mtvec_o, 32'h80);
    chk("rst_mstatus", mstatus_o, 32'h0);
    chk("rst_illegal", {31'd0, ex_illegal_o}, 32'd0);
    rdc("rst_mhartid", 12'hF14, 32'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) tick();
    rdc("cycle_10", 12'hC00, 32'd10);
    rdc("cycleh_0", 12'hC80, 32'd0);

    ex(2'b01, 12'h300, 32'hFFFF_FFFF);
    tick();
    ex(2'b11, 12'h300, 32'h8);
    #1;
    chk("rc_old", ex_data_o, 32'h88);
    chk("mstatus_88", mstatus_o, 32'h88);
    chk("gie_1", {31'd0, global_int_en_o}, 32'd1);
    tick();
    quiet();
    rdc("mstatus_80", 12'h300, 32'h80);
    chk("gie_0", {31'd0, global_int_en_o}, 32'd0);

    ex(2'b10, 12'h304, 32'h888);
    tick();
    quiet();
    #1 chk("mie_rs", mie_o, 32'h888);

    ex(2'b01, 12'hB00, 32'hFFFF_FFFF);
    cw(12'hB80, 32'h0);
    tick();
    quiet();
    rdc("mcycle_lo_w", 12'hB00, 32'hFFFF_FFFF);
    rdc("mcycleh_w", 12'hB80, 32'h0);
    tick();
    rdc("mcycle_wrap", 12'hB00, 32'h0);
    rdc("mcycleh_carry", 12'hB80, 32'h1);

    ex(2'b01, 12'h320, 32'h1);
    tick();
    quiet();
    tick();
    tick();
    rdc("cycle_frozen", 12'hC00, 32'h1);
    rdc("mcinh", 12'h320, 32'h1);
    retire_i = 1'b1;
    repeat (3) tick();
    retire_i = 1'b0;
    rdc("minstret_3", 12'hB02, 32'd3);
    rdc("instret_3", 12'hC02, 32'd3);

    ex(2'b01, 12'hC00, 32'h5);
    #1 chk("ill_ro", {31'd0, ex_illegal_o}, 32'd1);
    tick();
    quiet();
    rdc("ro_unchanged", 12'hC00, 32'h1);
    ex(2'b01, 12'h7C0, 32'h55);
    #1;
    chk("ill_unmapped", {31'd0, ex_illegal_o}, 32'd1);
    chk("unmapped_rd", ex_data_o, 32'h0);
    tick();
    ex(2'b10, 12'hC00, 32'h0);
    #1;
    chk("rs0_legal", {31'd0, ex_illegal_o}, 32'd0);
    chk("rs0_data", ex_data_o, 32'h1);
    tick();
    quiet();

    ex(2'b01, 12'h341, 32'h100);
    cw(12'h341, 32'h200);
    tick();
    quiet();
    #1 chk("mepc_ex_wins", mepc_o, 32'h100);
    ex(2'b01, 12'h340, 32'h0000_ABCD);
    cw(12'h342, 32'h8000_000B);
    tick();
    quiet();
    rdc("mscratch_both", 12'h340, 32'h0000_ABCD);
    rdc("mcause_both", 12'h342, 32'h8000_000B);

    ex(2'b01, 12'h305, 32'h1237);
    tick();
    quiet();
    #1 chk("mtvec_align", mtvec_o, 32'h1234);
    ex(2'b01, 12'h305, 32'h5550);
    #1 rst = 1'b0;
    #1;
    chk("midrst_mtvec", mtvec_o, 32'h80);
    chk("midrst_mepc", mepc_o, 32'h0);
    @(posedge clk);
    #1;
    quiet();
    rst = 1'b1;
    tick();
    #1 chk("post_rst_mtvec", mtvec_o, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
